// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for serial_adder.
// SERIAL_ADDER_FLAGS_EN adds the zr/ng status outputs.
interface serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;
`ifdef SERIAL_ADDER_FLAGS_EN
  logic             zr;
  logic             ng;
`endif

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, carry_out, overflow
`ifdef SERIAL_ADDER_FLAGS_EN
    , input zr, ng
`endif
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, carry_out, overflow
`ifdef SERIAL_ADDER_FLAGS_EN
    , output zr, ng
`endif
  );
endinterface

// File: rtl/serial_adder.sv
// Multi-cycle add/subtract: CHUNK bits per clock through a registered carry.
// Optional macro SERIAL_ADDER_FLAGS_EN adds registered zr/ng flags.
module serial_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_if.slave bus
);

  if (CHUNK < 1) begin : g_bad_chunk
    $fatal(1, "serial_adder: CHUNK must be >= 1");
  end else if (WIDTH % CHUNK != 0) begin : g_bad_div
    $fatal(1, "serial_adder: WIDTH must be a multiple of CHUNK");
  end

  localparam int NCH = (CHUNK >= 1) ? WIDTH / CHUNK : 1;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
  logic             carry_q, carry_d, a_msb_q, a_msb_d, b_msb_q, b_msb_d;
  logic             cout_q, cout_d, ovf_q, ovf_d, valid_q, valid_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CHUNK:0]   part;
`ifdef SERIAL_ADDER_FLAGS_EN
  logic             zr_q, zr_d, ng_q, ng_d;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_FLAGS_EN
    zr_d    = zr_q;
    ng_d    = ng_q;
`endif
    part = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + (CHUNK+1)'(carry_q);

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          // Subtraction as a + ~b + 1: the +1 enters as the initial carry.
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub;
          cnt_d   = '0;
          a_msb_d = bus.a[WIDTH-1];
          b_msb_d = bus.sub ^ bus.b[WIDTH-1];
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        res_d   = WIDTH'({part[CHUNK-1:0], res_q} >> CHUNK);
        carry_d = part[CHUNK];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          valid_d = 1'b1;
          sum_d   = res_d;
          cout_d  = part[CHUNK];
          ovf_d   = (a_msb_q == b_msb_q) && (res_d[WIDTH-1] != a_msb_q);
`ifdef SERIAL_ADDER_FLAGS_EN
          zr_d    = (res_d == '0);
          ng_d    = res_d[WIDTH-1];
`endif
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADDER_FLAGS_EN
      zr_q    <= 1'b0;
      ng_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_ADDER_FLAGS_EN
      zr_q    <= zr_d;
      ng_q    <= ng_d;
`endif
    end
  end

  assign bus.in_ready  = rst_n && (state_q == IDLE);
  assign bus.out_valid = valid_q;
  assign bus.sum       = sum_q;
  assign bus.carry_out = cout_q;
  assign bus.overflow  = ovf_q;
`ifdef SERIAL_ADDER_FLAGS_EN
  assign bus.zr        = zr_q;
  assign bus.ng        = ng_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: 16/4 and 4/4 instances checked against an arithmetic model.
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(16)) if16 ();
  serial_adder_if #(.WIDTH(4))  if4 ();

  serial_adder #(.WIDTH(16), .CHUNK(4)) u16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));
  serial_adder #(.WIDTH(4),  .CHUNK(4)) u4  (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

  // sel=0 steers stimulus to the 16-bit instance, sel=1 to the 4-bit one
  bit          sel = 1'b0;
  logic [15:0] t_a = '0, t_b = '0;
  logic        t_sub = 1'b0, t_in_valid = 1'b0, t_out_ready = 1'b0;

  assign if16.in_valid  = t_in_valid && !sel;
  assign if16.a         = t_a;
  assign if16.b         = t_b;
  assign if16.sub       = t_sub;
  assign if16.out_ready = t_out_ready && !sel;
  assign if4.in_valid   = t_in_valid && sel;
  assign if4.a          = t_a[3:0];
  assign if4.b          = t_b[3:0];
  assign if4.sub        = t_sub;
  assign if4.out_ready  = t_out_ready && sel;

  wire        o_in_ready  = sel ? if4.in_ready  : if16.in_ready;
  wire        o_out_valid = sel ? if4.out_valid : if16.out_valid;
  wire [15:0] o_sum       = sel ? {12'h000, if4.sum} : if16.sum;
  wire        o_cout      = sel ? if4.carry_out : if16.carry_out;
  wire        o_ovf       = sel ? if4.overflow  : if16.overflow;
`ifdef SERIAL_ADDER_FLAGS_EN
  wire        o_zr        = sel ? if4.zr : if16.zr;
  wire        o_ng        = sel ? if4.ng : if16.ng;
`endif

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  task automatic model(input int w, input int a, input int b, input bit sub,
                       output int s, output bit co, output bit ov, output bit zr, output bit ng);
    int m, raw, sa, sb, sr;
    m   = 1 << w;
    raw = sub ? a - b : a + b;
    s   = raw & (m - 1);
    co  = sub ? (a >= b) : (raw >= m);
    sa  = (a >= m / 2) ? a - m : a;
    sb  = (b >= m / 2) ? b - m : b;
    sr  = sub ? sa - sb : sa + sb;
    ov  = (sr < -(m / 2)) || (sr >= m / 2);
    zr  = (s == 0);
    ng  = (s >= m / 2);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_result(input string tag, input int s, input bit co, input bit ov,
                              input bit zr, input bit ng);
    check({tag, ".sum"}, 32'(o_sum), 32'(s));
    check({tag, ".cout"}, 32'(o_cout), 32'(co));
    check({tag, ".ovf"}, 32'(o_ovf), 32'(ov));
`ifdef SERIAL_ADDER_FLAGS_EN
    check({tag, ".zr"}, 32'(o_zr), 32'(zr));
    check({tag, ".ng"}, 32'(o_ng), 32'(ng));
`else
    if (zr && ng) check({tag, ".zr_ng"}, 32'(zr && ng), 32'd0);
`endif
  endtask

  // One full transaction; called at #1 after an edge with the DUT in IDLE.
  task automatic do_op(input string tag, input int w, input int a, input int b,
                       input bit sub, input int hold);
    int s, lat;
    bit co, ov, zr, ng;
    model(w, a, b, sub, s, co, ov, zr, ng);
    sel = (w == 4);
    #0;
    check({tag, ".in_ready"}, 32'(o_in_ready), 32'd1);
    t_a = 16'(a); t_b = 16'(b); t_sub = sub; t_in_valid = 1'b1;
    step();
    t_in_valid = 1'b0;
    lat = 0;
    while (!o_out_valid && lat < 40) begin
      step();
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), (w == 16) ? 32'd4 : 32'd1);
    check_result(tag, s, co, ov, zr, ng);
    repeat (hold) step();
    if (hold > 0) check({tag, ".held_sum"}, 32'(o_sum), 32'(s));
    t_out_ready = 1'b1;
    step();
    t_out_ready = 1'b0;
    check({tag, ".valid_drop"}, 32'(o_out_valid), 32'd0);
    check({tag, ".ready_back"}, 32'(o_in_ready), 32'd1);
    check({tag, ".sum_kept"}, 32'(o_sum), 32'(s));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, lat;
    bit co, ov, zr, ng;

    // Reset state
    #2;
    check("rst.in_ready", 32'(o_in_ready), 32'd0);
    check("rst.out_valid", 32'(o_out_valid), 32'd0);
    check("rst.sum", 32'(o_sum), 32'd0);
    check("rst.cout", 32'(o_cout), 32'd0);
    check("rst.ovf", 32'(o_ovf), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("rel.in_ready", 32'(o_in_ready), 32'd1);

    // Directed cases
    do_op("add_5555", 16, 16'h1234, 16'h4321, 1'b0, 0);
    do_op("add_wrap", 16, 16'hFFFF, 16'h0001, 1'b0, 0);
    do_op("add_ovf",  16, 16'h7FFF, 16'h0001, 1'b0, 0);
    do_op("sub_neg",  16, 16'h0005, 16'h0007, 1'b1, 0);
    do_op("sub_ovf",  16, 16'h8000, 16'h0001, 1'b1, 0);
    do_op("sub_zero", 16, 16'h1234, 16'h0000, 1'b1, 1);
    do_op("sub_min",  16, 16'h0001, 16'h8000, 1'b1, 0);

    // Backpressure with a competing operand presented during DONE
    sel = 1'b0;
    model(16, 16'h1111, 16'h2222, 1'b0, s, co, ov, zr, ng);
    t_a = 16'h1111; t_b = 16'h2222; t_sub = 1'b0; t_in_valid = 1'b1;
    step();
    t_in_valid = 1'b0;
    lat = 0;
    while (!o_out_valid && lat < 40) begin
      step();
      lat++;
    end
    check("bp.latency", 32'(lat), 32'd4);
    t_a = 16'hAAAA; t_b = 16'h5555; t_sub = 1'b1; t_in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp.hold_valid", 32'(o_out_valid), 32'd1);
      check("bp.hold_ready", 32'(o_in_ready), 32'd0);
      check_result("bp.hold", s, co, ov, zr, ng);
    end
    t_out_ready = 1'b1;
    step();
    t_out_ready = 1'b0;
    check("bp.valid_drop", 32'(o_out_valid), 32'd0);
    check("bp.ready_back", 32'(o_in_ready), 32'd1);
    check("bp.sum_kept", 32'(o_sum), 32'(s));
    t_in_valid = 1'b0;
    step();
    check("bp.still_idle", 32'(o_in_ready), 32'd1);

    // Asynchronous reset two cycles into RUN
    t_a = 16'h0F0F; t_b = 16'h0101; t_sub = 1'b0; t_in_valid = 1'b1;
    step();
    t_in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("arst.out_valid", 32'(o_out_valid), 32'd0);
    check("arst.sum", 32'(o_sum), 32'd0);
    check("arst.in_ready", 32'(o_in_ready), 32'd0);
    step();
    step();
    check("arst.sum_held", 32'(o_sum), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("arst.rel_ready", 32'(o_in_ready), 32'd1);
    do_op("post_rst", 16, 16'h0003, 16'h0004, 1'b0, 0);

    // Randomized 16-bit ops with random backpressure
    for (int i = 0; i < 40; i++) begin
      do_op("rand16", 16, int'($urandom_range(0, 16'hFFFF)), int'($urandom_range(0, 16'hFFFF)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    // Exhaustive 4-bit sweep on the single-chunk instance
    for (int sb = 0; sb < 2; sb++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          do_op("sweep4", 4, x, y, 1'(sb), 0);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
